// File: rtl/regfile_mp.sv
// regfile_mp: 2R/2W register file with per-register pending scoreboard and zero register at REGS-1.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp #(
  parameter int N = 64,
  parameter int REGS = 32,
  parameter int AW = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  output logic          busy1,
  output logic          busy2,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic [N-1:0]  wd3,
  input  logic          we4,
  input  logic [AW-1:0] wa4,
  input  logic [N-1:0]  wd4,
  input  logic          alloc_en,
  input  logic [AW-1:0] alloc_addr
);
  localparam logic [AW-1:0] XZR = AW'(REGS - 1);
  logic [N-1:0] mem [REGS];
  logic [REGS-1:0] pend;
  logic b3_1, b4_1, b3_2, b4_2;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < REGS; i++) mem[i] <= '0;
      pend <= '0;
    end else begin
      if (we3 && wa3 != XZR) mem[wa3] <= wd3;
      if (we4 && wa4 != XZR) mem[wa4] <= wd4;
      if (we3) pend[wa3] <= 1'b0;
      if (we4) pend[wa4] <= 1'b0;
      if (alloc_en && alloc_addr != XZR) pend[alloc_addr] <= 1'b1;
    end
`ifdef REGFILE_BYPASS_EN
  assign b3_1 = we3 && wa3 == ra1;
  assign b4_1 = we4 && wa4 == ra1;
  assign b3_2 = we3 && wa3 == ra2;
  assign b4_2 = we4 && wa4 == ra2;
`else
  assign b3_1 = 1'b0;
  assign b4_1 = 1'b0;
  assign b3_2 = 1'b0;
  assign b4_2 = 1'b0;
`endif
  // Outputs are forced to 0 during reset so forwarding cannot leak write data.
  always_comb begin
    rd1 = (!reset_n || ra1 == XZR) ? '0 : b4_1 ? wd4 : b3_1 ? wd3 : mem[ra1];
    rd2 = (!reset_n || ra2 == XZR) ? '0 : b4_2 ? wd4 : b3_2 ? wd3 : mem[ra2];
    busy1 = (!reset_n || ra1 == XZR || b3_1 || b4_1) ? 1'b0 : pend[ra1];
    busy2 = (!reset_n || ra2 == XZR || b3_2 || b4_2) ? 1'b0 : pend[ra2];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scenarios with literal checks plus a per-cycle reference-model comparison.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [4:0] ra1 = '0, ra2 = '0, wa3 = '0, wa4 = '0, alloc_addr = '0;
  logic [63:0] rd1, rd2, wd3 = '0, wd4 = '0;
  logic busy1, busy2, we3 = 1'b0, we4 = 1'b0, alloc_en = 1'b0;
  logic run = 1'b0;
  int pass = 0, total = 0;
  logic [63:0] m [32];
  logic p [32];

  regfile_mp dut (
    .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .we3(we3), .wa3(wa3), .wd3(wd3),
    .we4(we4), .wa4(wa4), .wd4(wd4), .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  always #5 clk = ~clk;

  // Reference model: register contents and pending bits as plain arrays.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        m[i] <= '0;
        p[i] <= 1'b0;
      end
    end else begin
      if (we3 && wa3 != 5'd31) m[wa3] <= wd3;
      if (we4 && wa4 != 5'd31) m[wa4] <= wd4;
      if (we3) p[wa3] <= 1'b0;
      if (we4) p[wa4] <= 1'b0;
      if (alloc_en && alloc_addr != 5'd31) p[alloc_addr] <= 1'b1;
    end

  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (!reset_n || a == 5'd31) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we4 && wa4 == a) return wd4;
    if (we3 && wa3 == a) return wd3;
`endif
    return m[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!reset_n || a == 5'd31) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((we4 && wa4 == a) || (we3 && wa3 == a)) return 1'b0;
`endif
    return p[a];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk)
    if (run) begin
      check("model_rd1", rd1, exp_rd(ra1));
      check("model_rd2", rd2, exp_rd(ra2));
      check("model_busy1", {63'd0, busy1}, {63'd0, exp_busy(ra1)});
      check("model_busy2", {63'd0, busy2}, {63'd0, exp_busy(ra2)});
    end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    we3 = 1'b0;
    we4 = 1'b0;
    alloc_en = 1'b0;
  endtask

  initial begin
    repeat (2) cyc();
    reset_n = 1'b1;
    run = 1'b1;
    #1 check("reset_rd1", rd1, 64'd0);
    // X5 = 0xDEAD with alloc, then an asynchronous mid-cycle reset.
    we3 = 1'b1; wa3 = 5'd5; wd3 = 64'hDEAD; alloc_en = 1'b1; alloc_addr = 5'd5;
    cyc();
    idle(); ra1 = 5'd5;
    #1 check("x5_rd1", rd1, 64'hDEAD);
    check("x5_busy1", {63'd0, busy1}, 64'd1);
    we3 = 1'b1; wd3 = 64'hBEEF; alloc_en = 1'b1;
    reset_n = 1'b0;
    #1 check("async_rst_rd1", rd1, 64'd0);
    check("async_rst_busy1", {63'd0, busy1}, 64'd0);
    cyc();
    idle(); reset_n = 1'b1;
    #1 check("rst_discard_rd1", rd1, 64'd0);
    check("rst_discard_busy1", {63'd0, busy1}, 64'd0);
    // Zero register ignores writes and allocs.
    we3 = 1'b1; wa3 = 5'd31; wd3 = '1; alloc_en = 1'b1; alloc_addr = 5'd31;
    cyc();
    idle(); ra1 = 5'd31;
    #1 check("xzr_rd1", rd1, 64'd0);
    check("xzr_busy1", {63'd0, busy1}, 64'd0);
    // Same-address dual write: port B wins.
    we3 = 1'b1; we4 = 1'b1; wa3 = 5'd7; wa4 = 5'd7; wd3 = 64'h11; wd4 = 64'h22;
    cyc();
    idle(); ra2 = 5'd7;
    #1 check("conflict_rd2", rd2, 64'h22);
    // Scoreboard set by alloc, cleared by write.
    alloc_en = 1'b1; alloc_addr = 5'd9;
    cyc();
    idle(); ra1 = 5'd9;
    #1 check("sb_busy_set", {63'd0, busy1}, 64'd1);
    we3 = 1'b1; wa3 = 5'd9; wd3 = 64'h55;
    cyc();
    idle();
    #1 check("sb_busy_clr", {63'd0, busy1}, 64'd0);
    check("sb_rd1", rd1, 64'h55);
    // Alloc and write on the same edge: pending stays set, data lands.
    alloc_en = 1'b1; alloc_addr = 5'd3; we4 = 1'b1; wa4 = 5'd3; wd4 = 64'h77;
    cyc();
    idle(); ra1 = 5'd3; ra2 = 5'd3;
    #1 check("alloc_wr_busy1", {63'd0, busy1}, 64'd1);
    check("alloc_wr_busy2", {63'd0, busy2}, 64'd1);
    check("alloc_wr_rd1", rd1, 64'h77);
    // Same-cycle read of a register being written.
    ra1 = 5'd2; we3 = 1'b1; wa3 = 5'd2; wd3 = 64'hABC;
`ifdef REGFILE_BYPASS_EN
    #1 check("bypass_rd1", rd1, 64'hABC);
`else
    #1 check("bypass_rd1", rd1, 64'd0);
`endif
    cyc();
    idle();
    #1 check("post_write_rd1", rd1, 64'hABC);
    // Mixed traffic on both ports, checked by the model every cycle.
    for (int i = 0; i < 20; i++) begin
      we3 = i[0]; wa3 = 5'(i); wd3 = 64'(i * 3 + 1);
      we4 = (i % 3) != 0; wa4 = 5'(i + 14); wd4 = ~64'(i);
      alloc_en = i[1]; alloc_addr = 5'(i + 13);
      ra1 = 5'(i - 1); ra2 = 5'(i + 13);
      cyc();
    end
    idle();
    ra1 = 5'd4; ra2 = 5'd30;
    #1 check("mix_x4", rd1, 64'd0);
    check("mix_x30", rd2, 64'hFFFF_FFFF_FFFF_FFEF);
    cyc();
    run = 1'b0;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter N, default 64, data width in bits of each register.
REQ-002 Parameter REGS, default 32, register count; power of two, at least 4.
REQ-003 Parameter AW, default $clog2(REGS), address width.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  input  1  single clock, all state updates on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- ra1, ra2  input  AW  read addresses.
- rd1, rd2  output  N  read data.
- busy1, busy2  output  1  scoreboard pending bit of ra1 / ra2.
- we3  input  1  write enable, port A.
- wa3  input  AW  write address, port A.
- wd3  input  N  write data, port A.
- we4  input  1  write enable, port B.
- wa4  input  AW  write address, port B.
- wd4  input  N  write data, port B.
- alloc_en  input  1  mark a register as pending (producer issued).
- alloc_addr  input  AW  register to mark as pending.

Function
REQ-005 The array SHALL hold REGS registers of N bits, written only on the rising edge of clk.
REQ-006 Reads SHALL be combinational: rd1 = reg[ra1], rd2 = reg[ra2]; busy1 and busy2 follow the same rule.
REQ-007 Register REGS-1 is the zero register (XZR).
- Writes to it SHALL be discarded.
- Reads of it SHALL return 0.
- Its busy bit SHALL always read 0, and alloc to it SHALL be ignored.
REQ-008 When we3 and we4 are both set and wa3 == wa4, port B (wd4) SHALL win and port A SHALL be dropped.
REQ-009 Each register SHALL have a pending bit.
- Set at the edge when alloc_en=1 and alloc_addr matches.
- Cleared at the edge when any enabled write port targets it.
REQ-010 When an alloc and a write hit the same register at the same edge, the pending bit SHALL end at 1 (alloc wins) and the data SHALL still be written.
REQ-011 A write to a register whose pending bit is 0 SHALL be accepted normally; there is no error flag.
REQ-012 Write-to-read latency without bypass SHALL be one cycle: data written at edge k is visible on rd1/rd2 after edge k.
REQ-013 The block SHALL contain no other state; a port with its enable at 0 SHALL change nothing.

Reset
REQ-014 While reset_n=0, asynchronously:
- All registers SHALL clear to 0.
- All pending bits SHALL clear to 0.
- rd1, rd2, busy1 and busy2 SHALL read 0.
REQ-015 Writes and allocs SHALL be ignored while reset_n=0.
REQ-016 A reset asserted mid-cycle SHALL discard any write or alloc presented in that cycle.

Configuration
REQ-017 Macro REGFILE_BYPASS_EN selects same-cycle forwarding.
- Defined: when ra1 or ra2 equals an enabled write address that is not XZR, rd SHALL return that write data combinationally, with port B taking priority over port A, and busy SHALL read 0 for that address.
- Not defined: reads SHALL return the stored value and the stored pending bit only.

Verification
REQ-018 The bench SHALL cover these directed scenarios (N=64, REGS=32):
- Reset: pulse reset_n=0 after writing X5=0xDEAD; set ra1=5 -> rd1=0 and busy1=0 immediately, without waiting for a clock edge.
- XZR: we3=1, wa3=31, wd3=0xFFFF_FFFF_FFFF_FFFF; next cycle ra1=31 -> rd1=0; alloc_addr=31 -> busy=0.
- Dual-port conflict: we3=we4=1, wa3=wa4=7, wd3=0x11, wd4=0x22; next cycle ra2=7 -> rd2=0x22.
- Scoreboard: alloc X9 -> busy1=1 for ra1=9; next edge we3=1 to X9 with wd3=0x55 -> busy1=0 and rd1=0x55.
- Simultaneous alloc and write to X3 with wd4=0x77 -> after the edge, busy=1 and rd=0x77.
- Bypass: we3=1, wa3=2, wd3=0xABC, ra1=2 in the same cycle -> rd1=0xABC before the edge with REGFILE_BYPASS_EN defined; the old value (0) without it.
